serial_tx: RTL
==============

Name: serial_tx

Overview:
- Serial transmitter that sends one parallel word per frame over a single line.
- Frame format: start bit (0), WIDTH data bits LSB-first, stop bit (1). Line idles high.
- Bit timing comes from an internal cycle counter, with the same divide-by-N scheme as the clock divider.
- Feeds an external receiver built from the Synchronizer and a right-shifting SIPO shift register.

Parameters:
WIDTH, 8, data bits per frame (must be >= 2)
CYCLES_PER_BIT, 3975, clock cycles each line bit is held (must be >= 2)

Ports:
clock  input  1  system clock, rising edge
reset_L  input  1  asynchronous active-low reset
data  input  WIDTH  word to send; sampled only on handshake
valid  input  1  producer has a word on data
ready  output  1  transmitter can accept a word (1 only in IDLE)
serial_out  output  1  serial line, registered, idles 1
busy  output  1  frame in progress (= ~ready)

Behaviour:
- Reset (reset_L=0, asynchronous):
  - state=IDLE, serial_out=1, ready=1, busy=0.
  - Bit counter and shift register cleared.
  - Reset mid-frame aborts the frame: the line returns to 1 immediately, with no partial stop bit.
- Handshake:
  - A word is accepted on a rising edge where valid=1 and ready=1. That edge is "edge 0".
  - data is latched into the shift register on edge 0. Later changes on data have no effect on the frame.
  - valid while ready=0 is ignored; nothing is queued.
- State machine (typedef tx_state_t): IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: serial_out=1, ready=1. On handshake, go to START.
  - START: serial_out=0 for CYCLES_PER_BIT cycles, then go to DATA.
  - DATA: serial_out=shreg[0]. On each bit_done, shift right and increment the bit index. After WIDTH bits, go to STOP.
  - STOP: serial_out=1 for CYCLES_PER_BIT cycles, then go to IDLE.
- Timing, counted from edge 0:
  - Start bit driven after edge 0.
  - Data bit i driven after edge (1+i)*CYCLES_PER_BIT.
  - Stop bit driven after edge (WIDTH+1)*CYCLES_PER_BIT.
  - ready=1 again after edge (WIDTH+2)*CYCLES_PER_BIT.
- Frame length is (WIDTH+2)*CYCLES_PER_BIT cycles.
- Back-to-back: with valid held high, the next accept happens at edge (WIDTH+2)*CYCLES_PER_BIT+1. This gives exactly one idle-high cycle between frames.
- Bit counter:
  - Width $clog2(CYCLES_PER_BIT). Counts 0..CYCLES_PER_BIT-1.
  - bit_done asserts when the count equals CYCLES_PER_BIT-1; the counter wraps to 0 on that cycle.
  - Counter is cleared on handshake and held at 0 in IDLE.
- Bit index: width $clog2(WIDTH+1). Never exceeds WIDTH.
- serial_out is driven from a flop and is glitch-free. busy is combinational from state.

Optional Feature:
- Macro SERIAL_TX_PARITY_EN.
- Defined:
  - State PARITY is inserted between DATA and STOP.
  - It transmits even parity: the XOR of the latched word, computed at accept.
  - The bit is held CYCLES_PER_BIT cycles.
  - Frame length becomes (WIDTH+3)*CYCLES_PER_BIT.
- Undefined: no PARITY state, no parity logic, and the frame is as above.

Decomposition:
- Package serial_pkg:
  - typedef enum tx_state_t {IDLE, START, DATA, STOP, PARITY}. PARITY is present in the enum regardless of the macro.
  - Constants START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LEVEL=1'b1.
- Sub-module bit_timer (parameter CYCLES_PER_BIT):
  - Inputs: clock, reset_L, clear, en.
  - Output: bit_done.
  - Internally a counter plus equality compare.
- Top level holds the FSM, shift register and bit index.

Test Plan (WIDTH=8, CYCLES_PER_BIT=4):
1. reset_L=0 for 3 cycles with valid=1 -> serial_out=1, ready=1, busy=0 throughout; no frame starts until reset_L=1.
2. Send 8'hA5 -> serial_out is 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; ready=0 for 40 cycles; ready=1 at cycle 41.
3. valid held with 8'h00 then 8'hFF -> second accept 41 cycles after the first; one idle-1 cycle between the stop bit and the next start bit; second frame 0,1×8,1.
4. Send 8'h5A, then pulse valid with 8'h3C and change data at cycle 10 -> transmitted bits still match 8'h5A; 8'h3C is never sent.
5. reset_L=0 during data bit 3 of 8'hC3 -> serial_out=1 in the same cycle; after release, ready=1, and a new 8'h81 frame transmits correctly.
6. SERIAL_TX_PARITY_EN defined, send 8'h07 -> parity bit=1 after data bit 7; frame is 44 cycles; send 8'h03 -> parity bit=0.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and line levels for the serial transmitter.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        PARITY
    } tx_state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/serial_tx_bit_timer.sv
// Divide-by-N bit timer: bit_done pulses on the last cycle of every bit period.
module bit_timer #(
    parameter int CYCLES_PER_BIT = 3975
) (
    input  logic clock,
    input  logic reset_L,
    input  logic clear,
    input  logic en,
    output logic bit_done
);

    localparam int CW = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLES_PER_BIT - 1);

    logic [CW-1:0] count_q;

    assign bit_done = en && (count_q == LAST);

    // Counter rests at zero while disabled so every bit starts a full period.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            count_q <= '0;
        end else if (clear || !en) begin
            count_q <= '0;
        end else if (count_q == LAST) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/serial_tx.sv
// Start/data(LSB first)/stop serial transmitter with valid/ready input.
// Define SERIAL_TX_PARITY_EN to append an even-parity bit after the data bits.
module serial_tx
    import serial_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int CYCLES_PER_BIT = 3975
) (
    input  logic             clock,
    input  logic             reset_L,
    input  logic [WIDTH-1:0] data,
    input  logic             valid,
    output logic             ready,
    output logic             serial_out,
    output logic             busy
);

    localparam int IW = $clog2(WIDTH + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    tx_state_t        state_q;
    logic [WIDTH-1:0] shiftReg_q;
    logic [IW-1:0]    bitIdx_q;
    logic             serialOut_q;
`ifdef SERIAL_TX_PARITY_EN
    logic             parity_q;
`endif

    logic handshake;
    logic timerEn;
    logic bitDone;

    assign ready      = (state_q == IDLE);
    assign busy       = ~ready;
    assign serial_out = serialOut_q;
    assign handshake  = valid && ready;
    assign timerEn    = (state_q != IDLE);

    bit_timer #(
        .CYCLES_PER_BIT(CYCLES_PER_BIT)
    ) u_bitTimer (
        .clock   (clock),
        .reset_L (reset_L),
        .clear   (handshake),
        .en      (timerEn),
        .bit_done(bitDone)
    );

    // The line level for the next bit is loaded together with the state change,
    // so serial_out always comes straight from a flop.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_q     <= IDLE;
            shiftReg_q  <= '0;
            bitIdx_q    <= '0;
            serialOut_q <= IDLE_LEVEL;
`ifdef SERIAL_TX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    serialOut_q <= IDLE_LEVEL;
                    if (handshake) begin
                        shiftReg_q  <= data;
                        bitIdx_q    <= '0;
                        state_q     <= START;
                        serialOut_q <= START_BIT;
`ifdef SERIAL_TX_PARITY_EN
                        parity_q    <= ^data;
`endif
                    end
                end
                START: begin
                    if (bitDone) begin
                        state_q     <= DATA;
                        serialOut_q <= shiftReg_q[0];
                    end
                end
                DATA: begin
                    if (bitDone) begin
                        shiftReg_q <= shiftReg_q >> 1;
                        bitIdx_q   <= bitIdx_q + 1'b1;
                        if (bitIdx_q == LAST_IDX) begin
`ifdef SERIAL_TX_PARITY_EN
                            state_q     <= PARITY;
                            serialOut_q <= parity_q;
`else
                            state_q     <= STOP;
                            serialOut_q <= STOP_BIT;
`endif
                        end else begin
                            serialOut_q <= shiftReg_q[1];
                        end
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                PARITY: begin
                    if (bitDone) begin
                        state_q     <= STOP;
                        serialOut_q <= STOP_BIT;
                    end
                end
`endif
                STOP: begin
                    if (bitDone) begin
                        state_q     <= IDLE;
                        serialOut_q <= IDLE_LEVEL;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    serialOut_q <= IDLE_LEVEL;
                end
            endcase
        end
    end

endmodule
